// File: rtl/core_ctrl_pkg.sv
// ============================================================================
// Module      : core_ctrl_pkg
// Description : Shared types and constants for the queued core controller:
//               FSM state encoding, data-condition bit positions and the
//               instruction field layout [FPU_OP | ROUND_MODE].
// Options     : none (CORE_CTRL_WATCHDOG_EN is consumed by core_ctrl_queued)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT_MC = 3'd2,
    ST_START   = 3'd3,
    ST_PROC    = 3'd4,
    ST_ERR     = 3'd5
  } ctrl_state_t;

  // Bit positions inside ctrl_data_contition
  localparam int COND_HAS_DATA     = 3;
  localparam int COND_VALID_DATA   = 2;
  localparam int COND_HAS_DATA_R   = 1;
  localparam int COND_VALID_DATA_R = 0;

  // Instruction layout: ROUND_MODE occupies the LSBs, FPU_OP the rest
  localparam int ROUND_MODE_W   = 1;
  localparam int ROUND_MODE_LSB = 0;
  localparam int FPU_OP_LSB     = ROUND_MODE_W;

endpackage : core_ctrl_pkg

`default_nettype wire

// File: rtl/ctrl_inst_fifo.sv
// ============================================================================
// Module      : ctrl_inst_fifo
// Description : Instruction queue, DEPTH x WIDTH, first-word-fall-through.
//               A push is accepted while full if a pop happens in the same
//               cycle, leaving the occupancy unchanged.
// Ports       : i_clk, i_rst_n (async, active-low), i_push/i_data,
//               i_pop, o_data (head entry), o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_FULL_CNT);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // The slot freed by a same-cycle pop may be reused immediately
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ctrl_inst_fifo

`default_nettype wire

// File: rtl/core_ctrl_queued.sv
// ============================================================================
// Module      : core_ctrl_queued
// Description : Queued FPU core controller. Instructions are buffered in a
//               small queue; one at a time is popped, its operand beats are
//               written to the memory controller, and after the memory
//               commit the processing unit is started and awaited.
// Options     : CORE_CTRL_WATCHDOG_EN - adds a TMO_W-bit watchdog in WAIT_MC
//               and PROC that aborts to ERR when it saturates.
// Ports       : ctrl_clk, ctrl_reset (async, active-low)
//               ctrl_instruction/ctrl_valid_inst/ctrl_inst_ready : queue in
//               ctrl_valid_data/ctrl_last_data/ctrl_data_ready   : operands
//               ctrl_busy, ctrl_err, ctrl_data_contition         : status
//               mc_we/mc_data_address_out/mc_data_length         : to memory
//               mc_data_done, mc_err                             : from memory
//               procc_instruction/procc_start, procc_done        : FPU side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_ctrl_queued
  import core_ctrl_pkg::*;
#(
  parameter int INST_W = 3,
  parameter int ADDR_W = 6,
  parameter int QDEPTH = 4,
  parameter int TMO_W  = 8
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  input  logic [INST_W-1:0] ctrl_instruction,
  input  logic              ctrl_valid_inst,
  output logic              ctrl_inst_ready,
  input  logic              ctrl_valid_data,
  input  logic              ctrl_last_data,
  output logic              ctrl_data_ready,
  output logic              ctrl_busy,
  output logic              ctrl_err,
  output logic [3:0]        ctrl_data_contition,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_data_address_out,
  output logic [ADDR_W:0]   mc_data_length,
  input  logic              mc_data_done,
  input  logic              mc_err,
  output logic [INST_W-1:0] procc_instruction,
  output logic              procc_start,
  input  logic              procc_done
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next;

  logic [INST_W-1:0] w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [INST_W-1:0] r_procc_inst;
  logic              r_mc_done;
  logic              r_has_data;
  logic              r_valid_data;
  logic              r_has_data_r;
  logic              r_valid_data_r;

  logic              w_beat;
  logic              w_at_max;
  logic              w_tmo_hit;

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  assign w_pop           = (r_state == ST_IDLE) && !w_fifo_empty;
  // A full queue still accepts in the cycle IDLE pops its head
  assign ctrl_inst_ready = !w_fifo_full || w_pop;
  assign w_push          = ctrl_valid_inst && ctrl_inst_ready;

  ctrl_inst_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (INST_W)
  ) u_inst_fifo (
    .i_clk   (ctrl_clk),
    .i_rst_n (ctrl_reset),
    .i_push  (w_push),
    .i_data  (ctrl_instruction),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_beat   = (r_state == ST_LOAD) && ctrl_valid_data;
  assign w_at_max = (r_addr == '1);

  // --------------------------------------------------------------------------
  // Optional watchdog
  // --------------------------------------------------------------------------
`ifdef CORE_CTRL_WATCHDOG_EN
  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_state;
  logic             err_cause;   // 0 = memory/overflow, 1 = timeout

  assign w_tmo_state = (r_state == ST_WAIT_MC) || (r_state == ST_PROC);
  assign w_tmo_hit   = w_tmo_state && (&r_tmo);

  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_tmo     <= '0;
      err_cause <= 1'b0;
    end else begin
      // Restart on every state change so each guarded state gets a full budget
      if (!w_tmo_state || (w_next != r_state)) begin
        r_tmo <= '0;
      end else if (!(&r_tmo)) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
      if ((w_next == ST_ERR) && (r_state != ST_ERR)) begin
        err_cause <= w_tmo_hit && !mc_err;
      end
    end
  end
`else
  logic [TMO_W-1:0] w_tmo_unused;
  assign w_tmo_unused = '0;
  assign w_tmo_hit    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (mc_err) begin
          w_next = ST_ERR;
        end else if (w_beat && ctrl_last_data) begin
          w_next = ST_WAIT_MC;
        end else if (w_beat && w_at_max) begin
          // Buffer exhausted without a final beat: abort, never wrap
          w_next = ST_ERR;
        end
      end
      ST_WAIT_MC: begin
        // An error in the same cycle as the commit takes priority
        if (mc_err || w_tmo_hit) begin
          w_next = ST_ERR;
        end else if (r_mc_done) begin
          w_next = ST_START;
        end
      end
      ST_START: begin
        w_next = ST_PROC;
      end
      ST_PROC: begin
        if (procc_done) begin
          w_next = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_next = ST_ERR;
        end
      end
      ST_ERR: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and condition tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_addr         <= '0;
      r_len          <= '0;
      r_procc_inst   <= '0;
      r_mc_done      <= 1'b0;
      r_has_data     <= 1'b0;
      r_valid_data   <= 1'b0;
      r_has_data_r   <= 1'b0;
      r_valid_data_r <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_addr <= '0;
      end else if (w_beat && !w_at_max) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      // Length stays visible after the instruction until the next pop
      if (w_pop) begin
        r_len        <= '0;
        r_procc_inst <= w_fifo_dout;
      end else if (w_beat) begin
        r_len <= r_len + (ADDR_W + 1)'(1);
      end

      // The commit is held for one cycle before START so the memory side
      // has settled; an mc_err in the done cycle suppresses it
      r_mc_done <= (r_state == ST_WAIT_MC) && (w_next == ST_WAIT_MC) && mc_data_done;

      if (w_beat) begin
        r_has_data <= 1'b1;
      end
      if ((r_state == ST_LOAD) && (w_next == ST_WAIT_MC)) begin
        r_valid_data <= 1'b1;
      end
      if (r_state == ST_START) begin
        r_has_data_r   <= 1'b1;
        r_valid_data_r <= 1'b1;
      end
      // Validity belongs to one instruction; history bits persist
      if (w_next == ST_IDLE) begin
        r_valid_data   <= 1'b0;
        r_valid_data_r <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ctrl_data_ready     = (r_state == ST_LOAD);
  assign ctrl_busy           = (r_state != ST_IDLE) || !w_fifo_empty;
  assign ctrl_err            = (r_state == ST_ERR);
  assign mc_we               = w_beat;
  assign mc_data_address_out = r_addr;
  assign mc_data_length      = r_len;
  assign procc_instruction   = r_procc_inst;
  assign procc_start         = (r_state == ST_START);

  always_comb begin
    ctrl_data_contition                    = '0;
    ctrl_data_contition[COND_HAS_DATA]     = r_has_data;
    ctrl_data_contition[COND_VALID_DATA]   = r_valid_data;
    ctrl_data_contition[COND_HAS_DATA_R]   = r_has_data_r;
    ctrl_data_contition[COND_VALID_DATA_R] = r_valid_data_r;
  end

endmodule : core_ctrl_queued

`default_nettype wire
